// File: rtl/debug_dump_uart_if.sv
// rtl/debug_dump_uart_if.sv - display-mux select/word and UART status bundle for the debug dump block
interface debug_dump_uart_if;
    logic        Dump_Start;
    logic [5:0]  User_Select;
    logic        User_Enable;
    logic [31:0] HexDisplay32Bits;
    logic [5:0]  Display_Select;
    logic        Display_Enable;
    logic        UART_TXD;
    logic        Dump_Busy;
    logic        Dump_Done;

    modport slave (
        input  Dump_Start, User_Select, User_Enable, HexDisplay32Bits,
        output Display_Select, Display_Enable, UART_TXD, Dump_Busy, Dump_Done
    );

    modport master (
        output Dump_Start, User_Select, User_Enable, HexDisplay32Bits,
        input  Display_Select, Display_Enable, UART_TXD, Dump_Busy, Dump_Done
    );
endinterface

// File: rtl/debug_dump_uart.sv
// rtl/debug_dump_uart.sv - steps the display mux through a select range and sends each word as ASCII hex over UART
module debug_dump_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SEL_FIRST    = 32,
    parameter int SEL_LAST     = 38
) (
    input  logic             clock,
    input  logic             reset,
    debug_dump_uart_if.slave dbg
);
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_CAPTURE, S_SEND, S_DONE} state_t;
    typedef enum logic [1:0] {K_HEX, K_SPACE, K_CR, K_LF} kind_t;

    localparam int              CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   BAUD_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [5:0]      SEL_FIRST_V = 6'(SEL_FIRST);
    localparam logic [5:0]      SEL_LAST_V  = 6'(SEL_LAST);

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [5:0]    sel_q, sel_d;
    logic [5:0]    disp_sel_q, disp_sel_d;
    logic          disp_en_q, disp_en_d;
    logic          busy_q, busy_d;
    logic [31:0]   word_q, word_d;
    logic [2:0]    nib_q, nib_d;
    logic [7:0]    char_q, char_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] baud_q, baud_d;
    logic          txd;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    function automatic logic [3:0] nibble_of(input logic [31:0] w, input logic [2:0] idx);
        logic [31:0] sh;
        sh = w >> {idx, 2'b00};
        return sh[3:0];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kind_q     <= K_HEX;
            sel_q      <= SEL_FIRST_V;
            disp_sel_q <= '0;
            disp_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            word_q     <= '0;
            nib_q      <= '0;
            char_q     <= '0;
            bit_q      <= '0;
            baud_q     <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            sel_q      <= sel_d;
            disp_sel_q <= disp_sel_d;
            disp_en_q  <= disp_en_d;
            busy_q     <= busy_d;
            word_q     <= word_d;
            nib_q      <= nib_d;
            char_q     <= char_d;
            bit_q      <= bit_d;
            baud_q     <= baud_d;
        end
    end

    // Display outputs are loaded on entry to SELECT so the mux sees the new select during SELECT itself.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        sel_d      = sel_q;
        disp_sel_d = disp_sel_q;
        disp_en_d  = disp_en_q;
        busy_d     = busy_q;
        word_d     = word_q;
        nib_d      = nib_q;
        char_d     = char_q;
        bit_d      = bit_q;
        baud_d     = baud_q;

        case (state_q)
            S_IDLE: begin
                disp_sel_d = dbg.User_Select;
                disp_en_d  = dbg.User_Enable;
                if (dbg.Dump_Start) begin
                    state_d    = S_SELECT;
                    sel_d      = SEL_FIRST_V;
                    disp_sel_d = SEL_FIRST_V;
                    disp_en_d  = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_SELECT:  state_d = S_SETTLE;
            S_SETTLE:  state_d = S_CAPTURE;
            S_CAPTURE: begin
                word_d  = dbg.HexDisplay32Bits;
                nib_d   = 3'd7;
                char_d  = hex_ascii(dbg.HexDisplay32Bits[31:28]);
                kind_d  = K_HEX;
                bit_d   = '0;
                baud_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (baud_q != BAUD_LAST) begin
                    baud_d = baud_q + 1'b1;
                end else begin
                    baud_d = '0;
                    if (bit_q != 4'd9) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        bit_d = '0;
                        case (kind_q)
                            K_HEX: begin
                                if (nib_q != 3'd0) begin
                                    nib_d  = nib_q - 3'd1;
                                    char_d = hex_ascii(nibble_of(word_q, nib_q - 3'd1));
                                end else if (sel_q < SEL_LAST_V) begin
                                    kind_d = K_SPACE;
                                    char_d = 8'h20;
                                end else begin
                                    kind_d = K_CR;
                                    char_d = 8'h0D;
                                end
                            end
                            K_SPACE: begin
                                sel_d      = sel_q + 6'd1;
                                disp_sel_d = sel_q + 6'd1;
                                state_d    = S_SELECT;
                            end
                            K_CR: begin
                                kind_d = K_LF;
                                char_d = 8'h0A;
                            end
                            default: state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_comb begin
        txd = 1'b1;
        if (state_q == S_SEND) begin
            case (bit_q)
                4'd0:    txd = 1'b0;
                4'd9:    txd = 1'b1;
                default: txd = char_q[3'(bit_q - 4'd1)];
            endcase
        end
    end

    assign dbg.Display_Select = disp_sel_q;
    assign dbg.Display_Enable = disp_en_q;
    assign dbg.UART_TXD       = txd;
    assign dbg.Dump_Busy      = busy_q;
    assign dbg.Dump_Done      = (state_q == S_DONE);
endmodule
